// File: rtl/fetch_ar_pkg.sv
// fetch_ar_pkg
// Shared constants for the RV32S address-request stage:
//   - default reset PC
//   - instruction / address widths
//   - 2-bit FSM state encoding
package fetch_ar_pkg;

    localparam int          INST_W       = 32;
    localparam int          ADDR_W       = 32;
    localparam logic [31:0] PKG_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Sequential next PC; the 32-bit add wraps FFFF_FFFC to 0.
    function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf
// Holds the fetched instruction word and its sequential next PC.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears both regs)
//   load          : capture inst_in / snpc_in on this edge
//   inst_in       : instruction word from the read bus
//   snpc_in       : PC+4 of that instruction
//   inst, snpc    : registered outputs, stable while load is low
module fetch_buf
    import fetch_ar_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [INST_W-1:0] inst_in,
    input  logic [ADDR_W-1:0] snpc_in,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] snpc
);

    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] snpc_q, snpc_d;

    always_comb begin
        inst_d = inst_q;
        snpc_d = snpc_q;
        if (load) begin
            inst_d = inst_in;
            snpc_d = snpc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= '0;
            snpc_q <= '0;
        end else begin
            inst_q <= inst_d;
            snpc_q <= snpc_d;
        end
    end

    assign inst = inst_q;
    assign snpc = snpc_q;

endmodule

// File: rtl/fetch_ar.sv
// fetch_ar
// Address-request stage: owns the PC, issues one instruction read at a
// time, buffers the returned word with PC+4 and hands it to IF over a
// valid/ready handshake. pc_opt/dnpc redirects reload the PC and squash
// any buffered or in-flight instruction.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_REQ  | address presented (arvalid), waiting for arready
// S_WAIT | read accepted, waiting for rvalid
// S_FULL | instruction buffered, AR_valid to IF, waiting for IF_ready
// S_DROP | stale read outstanding, discard its data when it arrives
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   araddr/arvalid/arready    : instruction-memory read-address channel
//   rdata/rvalid/rready       : instruction-memory read-data channel
//   AR_valid/AR_inst/PC_snpc  : buffered instruction toward IF
//   IF_ready                  : IF accepts the buffered instruction
//   pc_opt/dnpc               : redirect request and target
module fetch_ar
    import fetch_ar_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic              AR_valid,
    output logic [INST_W-1:0] AR_inst,
    output logic [ADDR_W-1:0] PC_snpc,
    input  logic              IF_ready,
    input  logic              pc_opt,
    input  logic [ADDR_W-1:0] dnpc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] snpc;
    logic              buf_load;

    assign snpc = next_seq_pc(pc_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_load = 1'b0;

        // A redirect always wins; it only decides whether a read is
        // still outstanding (go drain it) or not (request immediately).
        if (pc_opt) begin
            pc_d = dnpc;
            unique case (state_q)
                S_REQ:   state_d = arready ? S_DROP : S_REQ;
                S_WAIT:  state_d = rvalid  ? S_REQ  : S_DROP;
                S_FULL:  state_d = S_REQ;
                S_DROP:  state_d = rvalid  ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (arready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rvalid) begin
                        buf_load = 1'b1;
                        pc_d     = snpc;
                        state_d  = S_FULL;
                    end
                end
                S_FULL: begin
                    if (IF_ready) state_d = S_REQ;
                end
                S_DROP: begin
                    if (rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .inst_in (rdata),
        .snpc_in (snpc),
        .inst    (AR_inst),
        .snpc    (PC_snpc)
    );

    assign araddr   = pc_q;
    // Reset already forces S_REQ, so the request is masked while rst is
    // held to keep the memory from seeing an address during reset.
    assign arvalid  = (state_q == S_REQ) && !rst;
    assign rready   = (state_q == S_WAIT) || (state_q == S_DROP);
    assign AR_valid = (state_q == S_FULL);

endmodule
